cook_sequencer: RTL

Cooking-cycle controller for the air fryer. It takes debounced key pulses and the power switch, holds the set time and heat mode, and sequences preheat, cook, pause and done phases. It drives the minute countdown, heater/fan enables, status LED and buzzer. Its outputs feed the segment display and dot-matrix blocks.

---
 rtl/cook_sequencer_if.sv | 29 ++
 rtl/cook_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cook_sequencer_if.sv
// Key inputs and display/actuator outputs of the air-fryer cooking sequencer.
// The key side drives the switch and button pulses; the sequencer drives the rest.
interface cook_sequencer_if;
    logic       SW3;
    logic       BTN0;
    logic       BTN1;
    logic       BTN3;
    logic       BTN4;
    logic       BTN6;
    logic       BTN7;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [1:0] mode;
    logic [2:0] state;
    logic       heater_on;
    logic       fan_on;
    logic       led;
    logic       buzzer;

    modport master (
        output SW3, BTN0, BTN1, BTN3, BTN4, BTN6, BTN7,
        input  min_tens, min_ones, mode, state, heater_on, fan_on, led, buzzer
    );

    modport slave (
        input  SW3, BTN0, BTN1, BTN3, BTN4, BTN6, BTN7,
        output min_tens, min_ones, mode, state, heater_on, fan_on, led, buzzer
    );
endinterface

// File: rtl/cook_sequencer.sv
// Air-fryer cooking-cycle controller: holds set time and heat mode, sequences
// preheat, cook, pause and done phases, and drives heater, fan, LED and buzzer.
module cook_sequencer #(
    parameter int TICKS_PER_SEC = 1000,
    parameter int SEC_PER_MIN   = 60,
    parameter int PREHEAT_SEC   = 30,
    parameter int DONE_SEC      = 3
) (
    input  logic            clk_1Khz,
    input  logic            rst,
    cook_sequencer_if.slave bus
);
    localparam int TW      = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int SEC_M1  = (SEC_PER_MIN > 3 * PREHEAT_SEC) ? SEC_PER_MIN : 3 * PREHEAT_SEC;
    localparam int SEC_MAX = (SEC_M1 > DONE_SEC) ? SEC_M1 : DONE_SEC;
    localparam int SW      = (SEC_MAX > 1) ? $clog2(SEC_MAX) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(TICKS_PER_SEC / 2);

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_IDLE    = 3'd1,
        S_PREHEAT = 3'd2,
        S_COOK    = 3'd3,
        S_PAUSE   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t        state_reg, state_next;
    logic          origin_cook_reg, origin_cook_next;
    logic [TW-1:0] tick_reg, tick_next;
    logic [SW-1:0] sec_reg, sec_next;
    logic [3:0]    tens_reg, tens_next;
    logic [3:0]    ones_reg, ones_next;
    logic [1:0]    mode_reg, mode_next;
    logic          heater_reg, heater_next;
    logic          fan_reg, fan_next;
    logic          led_reg, led_next;
    logic          buzzer_reg, buzzer_next;
    logic [SW-1:0] sec_last;
    logic          phase_end;
    logic          time_zero;

    always_ff @(posedge clk_1Khz) begin
        if (rst) begin
            state_reg       <= S_OFF;
            origin_cook_reg <= 1'b0;
            tick_reg        <= '0;
            sec_reg         <= '0;
            tens_reg        <= '0;
            ones_reg        <= '0;
            mode_reg        <= '0;
            heater_reg      <= 1'b0;
            fan_reg         <= 1'b0;
            led_reg         <= 1'b0;
            buzzer_reg      <= 1'b0;
        end else begin
            state_reg       <= state_next;
            origin_cook_reg <= origin_cook_next;
            tick_reg        <= tick_next;
            sec_reg         <= sec_next;
            tens_reg        <= tens_next;
            ones_reg        <= ones_next;
            mode_reg        <= mode_next;
            heater_reg      <= heater_next;
            fan_reg         <= fan_next;
            led_reg         <= led_next;
            buzzer_reg      <= buzzer_next;
        end
    end

    // Last second index of whichever timed phase is running.
    always_comb begin
        sec_last = SW'(DONE_SEC - 1);
        if (state_reg == S_COOK) begin
            sec_last = SW'(SEC_PER_MIN - 1);
        end else if (state_reg == S_PREHEAT) begin
            case (mode_reg)
                2'd0:    sec_last = SW'(PREHEAT_SEC - 1);
                2'd1:    sec_last = SW'(2 * PREHEAT_SEC - 1);
                default: sec_last = SW'(3 * PREHEAT_SEC - 1);
            endcase
        end
    end

    assign time_zero = (tens_reg == 4'd0) && (ones_reg == 4'd0);
    assign phase_end = (tick_reg == TICK_LAST) && (sec_reg == sec_last);

    always_comb begin
        state_next       = state_reg;
        origin_cook_next = origin_cook_reg;
        tick_next        = tick_reg;
        sec_next         = sec_reg;
        tens_next        = tens_reg;
        ones_next        = ones_reg;
        mode_next        = mode_reg;

        if (!bus.SW3) begin
            state_next = S_OFF;
            tick_next  = '0;
            sec_next   = '0;
            tens_next  = '0;
            ones_next  = '0;
            mode_next  = '0;
        end else begin
            case (state_reg)
                S_OFF: state_next = S_IDLE;
                S_IDLE: begin
                    if (bus.BTN1) begin
                        tens_next = '0;
                        ones_next = '0;
                    end else if (bus.BTN0 && !time_zero) begin
                        state_next = S_PREHEAT;
                        tick_next  = '0;
                        sec_next   = '0;
                    end else if (bus.BTN4) begin
                        mode_next = (mode_reg == 2'd2) ? 2'd0 : mode_reg + 2'd1;
                    end else begin
                        if (bus.BTN6) ones_next = (ones_reg == 4'd9) ? 4'd0 : ones_reg + 4'd1;
                        if (bus.BTN7) tens_next = (tens_reg == 4'd9) ? 4'd0 : tens_reg + 4'd1;
                    end
                end
                S_PAUSE: begin
                    if (bus.BTN1) begin
                        state_next = S_IDLE;
                        tick_next  = '0;
                        sec_next   = '0;
                        tens_next  = '0;
                        ones_next  = '0;
                    end else if (bus.BTN3 || bus.BTN0) begin
                        state_next = origin_cook_reg ? S_COOK : S_PREHEAT;
                    end
                end
                S_PREHEAT, S_COOK, S_DONE: begin
                    if (bus.BTN1) begin
                        state_next = S_IDLE;
                        tick_next  = '0;
                        sec_next   = '0;
                        tens_next  = '0;
                        ones_next  = '0;
                    end else if (bus.BTN3 && state_reg != S_DONE) begin
                        // The pausing cycle itself does not count, so resume picks up the same tick.
                        state_next       = S_PAUSE;
                        origin_cook_next = (state_reg == S_COOK);
                    end else begin
                        tick_next = (tick_reg == TICK_LAST) ? '0 : tick_reg + TW'(1);
                        if (tick_reg == TICK_LAST)
                            sec_next = (sec_reg == sec_last) ? '0 : sec_reg + SW'(1);
                        if (phase_end) begin
                            case (state_reg)
                                S_PREHEAT: state_next = S_COOK;
                                S_COOK: begin
                                    if (ones_reg == 4'd0) begin
                                        ones_next = 4'd9;
                                        tens_next = tens_reg - 4'd1;
                                    end else begin
                                        ones_next = ones_reg - 4'd1;
                                    end
                                    if (tens_reg == 4'd0 && ones_reg == 4'd1)
                                        state_next = S_DONE;
                                end
                                default: begin
                                    state_next = S_IDLE;
                                    tens_next  = '0;
                                    ones_next  = '0;
                                end
                            endcase
                        end
                    end
                end
                default: state_next = S_OFF;
            endcase
        end
    end

    // Outputs are derived from the next state/tick so the registered copies line up with state_reg.
    always_comb begin
        heater_next = (state_next == S_PREHEAT) || (state_next == S_COOK);
        fan_next    = heater_next || (state_next == S_DONE);
        buzzer_next = (state_next == S_DONE) && (tick_next < TICK_HALF);
        case (state_next)
            S_COOK:    led_next = 1'b1;
            S_PREHEAT: led_next = (tick_next < TICK_HALF);
            S_PAUSE:   led_next = led_reg;
            default:   led_next = 1'b0;
        endcase
    end

    assign bus.state     = state_reg;
    assign bus.min_tens  = tens_reg;
    assign bus.min_ones  = ones_reg;
    assign bus.mode      = mode_reg;
    assign bus.heater_on = heater_reg;
    assign bus.fan_on    = fan_reg;
    assign bus.led       = led_reg;
    assign bus.buzzer    = buzzer_reg;
endmodule
